adder_phase_seq: RTL and testbench
==================================

ADDER_PHASE_SEQ -- requirements
Module: adder_phase_seq

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width.
REQ-002 SHALL have parameter NPHASE, default 8, number of adder power-clock phases.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1 (legal 1..15), clk cycles per phase step.

Ports:
REQ-004 SHALL have ports: clk  in  1  single clock, rising-edge; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: req_valid  in  1; req_ready  out  1; req_a, req_b  in  WIDTH  operands; req_cin  in  1  carry-in.
REQ-006 SHALL have ports: resp_valid  out  1; resp_ready  in  1; resp_sum  out  WIDTH; resp_cout  out  1.
REQ-007 SHALL have ports: adder_a, adder_b  out  WIDTH  and adder_cin  out  1, all driving the adder; adder_out  in  WIDTH and adder_cout  in  1, from the adder.
REQ-008 SHALL have ports: phase_en  out  NPHASE  (bit k enables the clkpos[k]/clkneg[k] generator); busy  out  1; op_count  out  16  completed-operation count.

Function
REQ-009 SHALL assert req_ready only when state is IDLE and resp_valid is 0.
REQ-010 SHALL accept a request on the edge where req_valid and req_ready are both 1, register req_a/req_b/req_cin onto adder_a/adder_b/adder_cin and enter RAMP.
REQ-011 SHALL hold adder_a/adder_b/adder_cin stable from accept until return to IDLE.
REQ-012 SHALL use states IDLE -> RAMP -> RECOVER -> IDLE, with no other transitions except reset.
REQ-013 SHALL, with E0 as the accept edge, set phase_en[k] at edge E0+k*HOLD_CYCLES for k=0..NPHASE-1, giving all ones after edge E0+(NPHASE-1)*HOLD_CYCLES.
REQ-014 SHALL, at edge E0+NPHASE*HOLD_CYCLES, capture adder_out/adder_cout into resp_sum/resp_cout, set resp_valid, clear phase_en[NPHASE-1], increment op_count (wrap 0xFFFF->0) and enter RECOVER.
REQ-015 SHALL clear phase_en[NPHASE-1-j] at edge E0+(NPHASE+j)*HOLD_CYCLES for j=0..NPHASE-1, so phase bits fall in reverse order.
REQ-016 SHALL enter IDLE at edge E0+(2*NPHASE-1)*HOLD_CYCLES with phase_en all zero.
REQ-017 SHALL drive busy=1 in RAMP and RECOVER, and busy=0 in IDLE.
REQ-018 SHALL hold resp_valid/resp_sum/resp_cout until the edge where resp_valid and resp_ready are both 1, then clear resp_valid; if this handshake falls during RECOVER, the RECOVER sequence SHALL be unaffected.
REQ-019 SHALL ignore req_valid while busy, and ignore resp_ready while resp_valid=0.
REQ-020 SHALL never change more than one phase_en bit per edge.

Reset
REQ-021 SHALL, on rst_n low (including mid-operation), immediately force: state IDLE, phase_en=0, resp_valid=0, resp_sum=0, resp_cout=0, adder_a=0, adder_b=0, adder_cin=0, op_count=0, busy=0.
REQ-022 SHALL drive req_ready=1 on the first edge after rst_n deasserts.

Configuration
REQ-023 SHALL, with macro ADDER_PHASE_SEQ_CHECK_EN defined, add output chk_err (1 bit, reset 0) that is set sticky on the capture edge when {adder_cout,adder_out} != adder_a+adder_b+adder_cin and is cleared only by reset.
REQ-024 SHALL, without ADDER_PHASE_SEQ_CHECK_EN, omit the chk_err port and its logic entirely; all other behaviour SHALL be identical in both builds.

Structure
REQ-025 SHALL place the state enum (IDLE, RAMP, RECOVER) and the default WIDTH/NPHASE constants in shared package adder_seq_pkg.
REQ-026 SHALL implement the phase-step timing (HOLD_CYCLES prescaler plus step index 0..2*NPHASE-1) in sub-module phase_step_timer, instantiated once.

Verification
REQ-027 SHALL verify: HOLD_CYCLES=1, accept 0x1234+0x4321 cin=0 at E0 -> phase_en 0x01,0x03,..,0xFF after E0..E7; resp_valid=1, resp_sum=0x5555, resp_cout=0, phase_en=0x7F after E8; IDLE with phase_en=0 after E15.
REQ-028 SHALL verify: 0xFFFF+0x0000 cin=1 -> resp_sum=0x0000, resp_cout=1; op_count increments by 1.
REQ-029 SHALL verify: resp_ready held 0 for 30 cycles -> req_ready stays 0 after recovery, and response is unchanged; resp_ready=1 -> req_ready=1 on the next cycle.
REQ-030 SHALL verify: HOLD_CYCLES=3 -> each phase_en change occurs exactly 3 cycles apart, and resp_valid rises at E24.
REQ-031 SHALL verify: rst_n pulled low at E5 -> phase_en=0 and resp_valid=0 without waiting for a clock edge; the next request completes normally.
REQ-032 SHALL verify (check build): an adder model forced to return sum+1 -> chk_err=1 after capture and stays 1 until reset.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the phased adder sequencer.
// Holds the sequencer state encoding, the default datapath and phase widths,
// and a helper that sizes the phase-step index.
package adder_seq_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_NPHASE = 8;

    // Hold prescaler width; HOLD_CYCLES is limited to 1..15.
    localparam int HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        RECOVER = 2'd2
    } seq_state_t;

    // Bits needed for a step index that runs 0 .. 2*nphase-1.
    function automatic int step_width(input int nphase);
        return (nphase < 1) ? 1 : $clog2(2 * nphase);
    endfunction

endpackage

// File: rtl/phase_step_timer.sv
// Phase-step timebase for the adder sequencer.
// A down-counting prescaler reloads with HOLD_CYCLES-1 and fires a tick on
// terminal count; each tick advances the step index. The index restarts at 0
// on the accept edge, so step_next equals the event number (1 .. 2*NPHASE-1)
// that the current tick represents.
module phase_step_timer
    import adder_seq_pkg::*;
#(
    parameter int NPHASE      = DEFAULT_NPHASE,
    parameter int HOLD_CYCLES = 1,
    parameter int STEP_W      = step_width(NPHASE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              run,
    output logic              tick,
    output logic [STEP_W-1:0] step_next
);

    localparam logic [HOLD_W-1:0] PRE_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] pre_cnt;
    logic [STEP_W-1:0] step;

    // Prescaler and step index: restart on accept, advance on terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            step    <= '0;
        end else if (start) begin
            pre_cnt <= PRE_LOAD;
            step    <= '0;
        end else if (run) begin
            if (pre_cnt == '0) begin
                pre_cnt <= PRE_LOAD;
                step    <= step_next;
            end else begin
                pre_cnt <= pre_cnt - HOLD_W'(1);
            end
        end
    end

    assign tick      = run && (pre_cnt == '0);
    assign step_next = step + STEP_W'(1);

endmodule

// File: rtl/adder_phase_seq.sv
// Sequencer for an adiabatic adder driven by NPHASE power-clock phases.
// A request latches the operands onto the adder, ramps the phase enables up
// one bit per phase step, captures the sum, then ramps them down in reverse.
// Optional build macro ADDER_PHASE_SEQ_CHECK_EN adds a sticky chk_err output
// that flags a captured result disagreeing with a+b+cin.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no operation; accepts a request when no response is pending
// RAMP    | operands held, phase_en bits rising 0 .. NPHASE-1
// RECOVER | result captured, phase_en bits falling NPHASE-1 .. 0
module adder_phase_seq
    import adder_seq_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int NPHASE      = DEFAULT_NPHASE,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    input  logic              req_cin,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WIDTH-1:0]  resp_sum,
    output logic              resp_cout,
    output logic [WIDTH-1:0]  adder_a,
    output logic [WIDTH-1:0]  adder_b,
    output logic              adder_cin,
    input  logic [WIDTH-1:0]  adder_out,
    input  logic              adder_cout,
    output logic [NPHASE-1:0] phase_en,
    output logic              busy,
    output logic [15:0]       op_count
`ifdef ADDER_PHASE_SEQ_CHECK_EN
    ,
    output logic              chk_err
`endif
);

    localparam int STEP_W = step_width(NPHASE);
    localparam logic [STEP_W-1:0] CAP_STEP  = STEP_W'(NPHASE);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * NPHASE - 1);
    localparam logic [NPHASE-1:0] PHASE_ONE = NPHASE'(1);

    seq_state_t        state, state_nxt;
    logic [NPHASE-1:0] phase_en_nxt;
    logic [WIDTH-1:0]  adder_a_nxt, adder_b_nxt, resp_sum_nxt;
    logic              adder_cin_nxt, resp_cout_nxt, resp_valid_nxt;
    logic [15:0]       op_count_nxt;

    logic              accept;
    logic              capture;
    logic              tick;
    logic [STEP_W-1:0] step_next;

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) && !resp_valid;
    assign accept    = req_valid && req_ready;
    assign capture   = (state == RAMP) && tick && (step_next == CAP_STEP);

    phase_step_timer #(
        .NPHASE      (NPHASE),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STEP_W      (STEP_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept),
        .run       (busy),
        .tick      (tick),
        .step_next (step_next)
    );

    // State, operand, phase and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase_en   <= '0;
            adder_a    <= '0;
            adder_b    <= '0;
            adder_cin  <= 1'b0;
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            op_count   <= '0;
        end else begin
            state      <= state_nxt;
            phase_en   <= phase_en_nxt;
            adder_a    <= adder_a_nxt;
            adder_b    <= adder_b_nxt;
            adder_cin  <= adder_cin_nxt;
            resp_valid <= resp_valid_nxt;
            resp_sum   <= resp_sum_nxt;
            resp_cout  <= resp_cout_nxt;
            op_count   <= op_count_nxt;
        end
    end

    // Next-state and datapath updates; one phase bit moves per step tick.
    always_comb begin
        state_nxt      = state;
        phase_en_nxt   = phase_en;
        adder_a_nxt    = adder_a;
        adder_b_nxt    = adder_b;
        adder_cin_nxt  = adder_cin;
        resp_valid_nxt = resp_valid;
        resp_sum_nxt   = resp_sum;
        resp_cout_nxt  = resp_cout;
        op_count_nxt   = op_count;

        // Response drain is independent of the phase sequence.
        if (resp_valid && resp_ready) begin
            resp_valid_nxt = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (accept) begin
                    adder_a_nxt   = req_a;
                    adder_b_nxt   = req_b;
                    adder_cin_nxt = req_cin;
                    phase_en_nxt  = PHASE_ONE;
                    state_nxt     = RAMP;
                end
            end
            RAMP: begin
                if (capture) begin
                    resp_sum_nxt   = adder_out;
                    resp_cout_nxt  = adder_cout;
                    resp_valid_nxt = 1'b1;
                    op_count_nxt   = op_count + 16'd1;
                    phase_en_nxt   = phase_en & ~(PHASE_ONE << (NPHASE - 1));
                    // A single-phase adder has nothing left to ramp down.
                    state_nxt      = (NPHASE == 1) ? IDLE : RECOVER;
                end else if (tick) begin
                    phase_en_nxt = phase_en | (PHASE_ONE << step_next);
                end
            end
            RECOVER: begin
                if (tick) begin
                    phase_en_nxt = phase_en & ~(PHASE_ONE << (LAST_STEP - step_next));
                    if (step_next == LAST_STEP) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                phase_en_nxt = '0;
            end
        endcase
    end

`ifdef ADDER_PHASE_SEQ_CHECK_EN
    logic [WIDTH:0] chk_ref;

    assign chk_ref = {1'b0, adder_a} + {1'b0, adder_b} + {{WIDTH{1'b0}}, adder_cin};

    // Sticky flag for a captured result that disagrees with the held operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
        end else if (capture && ({adder_cout, adder_out} != chk_ref)) begin
            chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_phase_seq.sv
// Bench for adder_phase_seq: a HOLD_CYCLES=1 instance for handshake, data
// and reset behaviour, and a HOLD_CYCLES=3 instance for phase step spacing.
// Responses go through an expected-value queue drained by a monitor.
module tb_adder_phase_seq;

    localparam int W  = 16;
    localparam int NP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_cin, resp_valid, resp_ready, resp_cout;
    logic [W-1:0]  req_a, req_b, resp_sum, adder_a, adder_b, adder_out;
    logic          adder_cin, adder_cout, busy, chk_err;
    logic [NP-1:0] phase_en;
    logic [15:0]   op_count;
    logic          inj = 1'b0;

    logic          req_valid3, req_ready3, req_cin3, resp_valid3, resp_ready3, resp_cout3;
    logic [W-1:0]  req_a3, req_b3, resp_sum3, adder_a3, adder_b3, adder_out3;
    logic          adder_cin3, adder_cout3, busy3, chk_err3;
    logic [NP-1:0] phase_en3;
    logic [15:0]   op_count3;

    // Behavioural adders; inj makes the first one return sum+1.
    assign {adder_cout, adder_out} = {1'b0, adder_a} + {1'b0, adder_b}
                                     + 17'(adder_cin) + 17'(inj);
    assign {adder_cout3, adder_out3} = {1'b0, adder_a3} + {1'b0, adder_b3} + 17'(adder_cin3);

`ifndef ADDER_PHASE_SEQ_CHECK_EN
    assign chk_err  = 1'b0;
    assign chk_err3 = 1'b0;
`endif

    adder_phase_seq #(.WIDTH(W), .NPHASE(NP), .HOLD_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_cout(resp_cout),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_out(adder_out), .adder_cout(adder_cout),
        .phase_en(phase_en), .busy(busy), .op_count(op_count)
`ifdef ADDER_PHASE_SEQ_CHECK_EN
        , .chk_err(chk_err)
`endif
    );

    adder_phase_seq #(.WIDTH(W), .NPHASE(NP), .HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_cin(req_cin3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_sum(resp_sum3), .resp_cout(resp_cout3),
        .adder_a(adder_a3), .adder_b(adder_b3), .adder_cin(adder_cin3),
        .adder_out(adder_out3), .adder_cout(adder_cout3),
        .phase_en(phase_en3), .busy(busy3), .op_count(op_count3)
`ifdef ADDER_PHASE_SEQ_CHECK_EN
        , .chk_err(chk_err3)
`endif
    );

    int ncmp = 0;
    int nerr = 0;
    int model_ops = 0;
    logic [W:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Phase enables c cycles after the accept edge: one more bit per step on the
    // way up, one fewer per step on the way down after the capture step.
    function automatic logic [7:0] pe_model(input int c, input int h);
        int m;
        m = c / h;
        if (m < NP) return 8'((1 << (m + 1)) - 1);
        if (m < 2 * NP - 1) return 8'((1 << (2 * NP - 1 - m)) - 1);
        return 8'h00;
    endfunction

    // Monitor: every response handshake pops and compares one expected result.
    always @(negedge clk) begin
        logic [W:0] e;
        #1;
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL resp_unexpected: actual=%0h required=none", {resp_cout, resp_sum});
            end else begin
                e = exp_q.pop_front();
                check("resp_sum", 32'(resp_sum), 32'(e[W-1:0]));
                check("resp_cout", 32'(resp_cout), 32'(e[W]));
            end
        end
    end

    task automatic wait_req_ready(output bit ok);
        int g;
        g = 0;
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        ok = req_ready;
        if (!ok) check("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int resp_delay, input bit chk_phase);
        bit ok;
        int g;
        logic [W:0] e;
        @(negedge clk);
        resp_ready = (!chk_phase && resp_delay == 0);
        wait_req_ready(ok);
        if (!ok) return;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_cin = cin;
        e = {1'b0, a} + {1'b0, b} + 17'(cin) + 17'(inj);
        exp_q.push_back(e);
        model_ops++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        req_cin = 1'($urandom);
        if (chk_phase) begin
            for (int c = 0; c < 2 * NP; c++) begin
                check("phase_en", 32'(phase_en), 32'(pe_model(c, 1)));
                check("resp_valid_timing", 32'(resp_valid), 32'(c >= NP));
                check("busy", 32'(busy), 32'(c < 2 * NP - 1));
                check("adder_a_hold", 32'(adder_a), 32'(a));
                check("adder_b_hold", 32'(adder_b), 32'(b));
                if (c < 2 * NP - 1) @(negedge clk);
            end
        end else begin
            g = 0;
            while (busy && g < 200) begin
                @(negedge clk);
                g++;
            end
            check("busy_end", 32'(busy), 32'd0);
            check("phase_en_end", 32'(phase_en), 32'd0);
        end
        if (resp_valid) begin
            for (int i = 0; i < resp_delay; i++) begin
                check("req_ready_while_pending", 32'(req_ready), 32'd0);
                check("resp_sum_held", 32'(resp_sum), 32'(e[W-1:0]));
                @(negedge clk);
            end
            resp_ready = 1'b1;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        check("resp_valid_cleared", 32'(resp_valid), 32'd0);
        check("req_ready_after", 32'(req_ready), 32'd1);
        check("op_count", 32'(op_count), 32'(model_ops & 16'hFFFF));
    endtask

    initial begin
        logic [W:0] e3;
        logic [7:0] prev_pe;
        int last_chg;

        req_valid = 0; req_a = 0; req_b = 0; req_cin = 0; resp_ready = 0;
        req_valid3 = 0; req_a3 = 0; req_b3 = 0; req_cin3 = 0; resp_ready3 = 0;

        repeat (2) @(negedge clk);
        check("rst_phase_en", 32'(phase_en), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_adder_a", 32'(adder_a), 32'd0);
        check("rst_chk_err", 32'(chk_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", 32'(req_ready), 32'd1);

        do_op(16'h1234, 16'h4321, 1'b0, 2, 1'b1);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1, 1'b1);
        do_op(16'($urandom), 16'($urandom), 1'($urandom), 30, 1'b1);

        // Slow instance: phase bits move every 3 cycles, capture at E0+24.
        @(negedge clk);
        check("r3_ready", 32'(req_ready3), 32'd1);
        req_valid3 = 1'b1;
        req_a3 = 16'($urandom);
        req_b3 = 16'($urandom);
        req_cin3 = 1'($urandom);
        e3 = {1'b0, req_a3} + {1'b0, req_b3} + 17'(req_cin3);
        @(posedge clk);
        @(negedge clk);
        req_valid3 = 1'b0;
        prev_pe = 8'h00;
        last_chg = 0;
        for (int c = 0; c <= (2 * NP - 1) * 3; c++) begin
            check("phase_en3", 32'(phase_en3), 32'(pe_model(c, 3)));
            check("resp_valid3_timing", 32'(resp_valid3), 32'(c >= NP * 3));
            if (phase_en3 != prev_pe) begin
                if (c > 0) check("phase_step_spacing", 32'(c - last_chg), 32'd3);
                last_chg = c;
                prev_pe = phase_en3;
            end
            if (c == NP * 3) begin
                check("resp_sum3", 32'(resp_sum3), 32'(e3[W-1:0]));
                check("resp_cout3", 32'(resp_cout3), 32'(e3[W]));
            end
            if (c < (2 * NP - 1) * 3) @(negedge clk);
        end
        check("busy3_end", 32'(busy3), 32'd0);
        resp_ready3 = 1'b1;
        @(negedge clk);
        resp_ready3 = 1'b0;
        check("resp_valid3_cleared", 32'(resp_valid3), 32'd0);

        for (int i = 0; i < 24; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset in the middle of the ramp, then a normal operation.
        @(negedge clk);
        begin
            bit ok;
            wait_req_ready(ok);
            req_valid = 1'b1;
            req_a = 16'($urandom);
            req_b = 16'($urandom);
            req_cin = 1'b0;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            check("pre_reset_phase_en", 32'(phase_en), 32'h3F);
            #1;
            rst_n = 1'b0;
            #1;
            check("async_rst_phase_en", 32'(phase_en), 32'd0);
            check("async_rst_resp_valid", 32'(resp_valid), 32'd0);
            check("async_rst_busy", 32'(busy), 32'd0);
            check("async_rst_op_count", 32'(op_count), 32'd0);
            check("async_rst_adder_a", 32'(adder_a), 32'd0);
            exp_q.delete();
            model_ops = 0;
            @(negedge clk);
            rst_n = 1'b1;
        end
        do_op(16'hA5A5, 16'h0F0F, 1'b1, 0, 1'b1);

`ifdef ADDER_PHASE_SEQ_CHECK_EN
        check("chk_err_clean", 32'(chk_err), 32'd0);
        inj = 1'b1;
        do_op(16'h0102, 16'h0304, 1'b0, 0, 1'b0);
        inj = 1'b0;
        check("chk_err_set", 32'(chk_err), 32'd1);
        do_op(16'($urandom), 16'($urandom), 1'b0, 1, 1'b0);
        check("chk_err_sticky", 32'(chk_err), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("chk_err_reset", 32'(chk_err), 32'd0);
        exp_q.delete();
        model_ops = 0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
